send_scheduler: RTL and testbench

//  Parametrised packet-issue scheduler for the TX path, sitting between max_count_gen/switch decode and the byte_data/frame builder.

---
 rtl/send_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_send_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_scheduler.sv
// rtl/send_scheduler.sv - packet-issue scheduler walking (txid, segment) pairs for the TX path
//
// Purpose:
//   Issues one start_sending pulse per packet for every (txid, segment) pair of a
//   round, in block order (all segments of id 1, then id 2, ...) or interleaved
//   order (all ids of segment 0, then segment 1, ...).
//   Before each issue it waits for gap_cycles+1 cycles in which the sender is not busy.
//   Rounds are either free-running or started one at a time by start_frame.
//   maxdetect can shorten the segment count of the round in progress.
//
// Ports:
//   clk125MHz      system clock
//   RST_N          asynchronous active-low reset
//   enable         schedule rounds; when low, stop at the next round boundary
//   frame_mode     0 = free-running rounds, 1 = each round waits for start_frame
//   interleave     0 = block order, 1 = interleaved order
//   seg_max        segments per round (0 means 1), latched at round start
//   redundancy     copies per segment (0 means 1, clamped to MAX_RED), latched at round start
//   gap_cycles     non-busy idle cycles before each issue
//   busy           sender busy; holds the gap counter at 0
//   start_frame    round trigger pulse, honoured only in IDLE with frame_mode=1
//   maxdetect      source exhausted; makes the current segment the last one
//   start_sending  1-cycle issue pulse
//   segment_num    segment of the issued packet
//   txid           copy id of the issued packet (1..R)
//   aux            aux_base + segment_num, wrapping
//   seg_count      effective segment count of the current round
//   round_done     1-cycle pulse after the last packet of a round
//   active         high from round start until round_done
module send_scheduler #(
    parameter int SEG_W   = 16,
    parameter int ID_W    = 8,
    parameter int MAX_RED = 4,
    parameter int GAP_W   = 28,
    parameter int AUX_W   = 8
) (
    input  logic             clk125MHz,
    input  logic             RST_N,
    input  logic             enable,
    input  logic             frame_mode,
    input  logic             interleave,
    input  logic [SEG_W-1:0] seg_max,
    input  logic [ID_W-1:0]  redundancy,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             busy,
    input  logic             start_frame,
    input  logic             maxdetect,
    output logic             start_sending,
    output logic [SEG_W-1:0] segment_num,
    output logic [ID_W-1:0]  txid,
    output logic [AUX_W-1:0] aux,
    output logic [SEG_W-1:0] seg_count,
    output logic             round_done,
    output logic             active
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GAP   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_ADV   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state;
    logic [SEG_W-1:0] seg;
    logic [SEG_W-1:0] seg_lim;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  red_lim;
    logic [GAP_W-1:0] cnt;
    logic [AUX_W-1:0] aux_base;
    logic             truncated;

    logic [SEG_W-1:0] seg_init;
    logic [ID_W-1:0]  red_init;
    logic             last_seg;
    logic             last_id;
    logic             round_end;
    logic             trunc_hit;
    logic             start_round;

    always_comb begin
        seg_init = (seg_max == '0) ? SEG_W'(1) : seg_max;
        if (redundancy == '0)
            red_init = ID_W'(1);
        else if (redundancy > ID_W'(MAX_RED))
            red_init = ID_W'(MAX_RED);
        else
            red_init = redundancy;
    end

    assign last_seg  = (seg == seg_lim - SEG_W'(1));
    assign last_id   = (id == red_lim);
    assign round_end = last_seg & last_id;

    // In block order only the first copy walks every segment, so only id 1 may
    // truncate; later copies of the same segment must not re-trigger.
    assign trunc_hit = maxdetect & ~truncated & (interleave | (id == ID_W'(1)));

    // A round starts from IDLE on request, or straight out of DONE when free-running.
    assign start_round = ((state == ST_IDLE) & enable & (~frame_mode | start_frame)) |
                         ((state == ST_DONE) & enable & ~frame_mode);

    assign seg_count = seg_lim;

    always_ff @(posedge clk125MHz or negedge RST_N) begin
        if (!RST_N) begin
            state         <= ST_IDLE;
            seg           <= '0;
            seg_lim       <= '0;
            id            <= ID_W'(1);
            red_lim       <= ID_W'(1);
            cnt           <= '0;
            aux_base      <= '0;
            truncated     <= 1'b0;
            start_sending <= 1'b0;
            segment_num   <= '0;
            txid          <= ID_W'(1);
            aux           <= '0;
            round_done    <= 1'b0;
            active        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_GAP: begin
                    if (!busy && cnt == gap_cycles) begin
                        state         <= ST_ISSUE;
                        start_sending <= 1'b1;
                        segment_num   <= seg;
                        txid          <= id;
                        aux           <= aux_base + AUX_W'(seg);
                        cnt           <= '0;
                    end else begin
                        cnt <= busy ? '0 : cnt + GAP_W'(1);
                    end
                end
                ST_ISSUE: begin
                    start_sending <= 1'b0;
                    // seg_lim is already shortened when ADV evaluates round_end.
                    if (trunc_hit) begin
                        seg_lim   <= seg + SEG_W'(1);
                        truncated <= 1'b1;
                    end
                    state <= ST_ADV;
                end
                ST_ADV: begin
                    if (round_end) begin
                        round_done <= 1'b1;
                        active     <= 1'b0;
                        aux_base   <= aux_base + AUX_W'(seg_lim);
                        state      <= ST_DONE;
                    end else begin
                        if (!interleave) begin
                            if (!last_seg) begin
                                seg <= seg + SEG_W'(1);
                            end else begin
                                seg <= '0;
                                id  <= id + ID_W'(1);
                            end
                        end else begin
                            if (!last_id) begin
                                id <= id + ID_W'(1);
                            end else begin
                                id  <= ID_W'(1);
                                seg <= seg + SEG_W'(1);
                            end
                        end
                        state <= ST_GAP;
                    end
                end
                ST_DONE: begin
                    round_done <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the case so it overrides the DONE -> IDLE move.
            if (start_round) begin
                seg_lim   <= seg_init;
                red_lim   <= red_init;
                seg       <= '0;
                id        <= ID_W'(1);
                cnt       <= '0;
                truncated <= 1'b0;
                active    <= 1'b1;
                state     <= ST_GAP;
            end
        end
    end

endmodule

// File: tb/tb_send_scheduler.sv
// tb/tb_send_scheduler.sv - self-checking bench for send_scheduler
module tb_send_scheduler;

    localparam int MAX_RED = 4;

    logic        clk125MHz = 1'b0;
    logic        RST_N;
    logic        enable;
    logic        frame_mode;
    logic        interleave;
    logic [15:0] seg_max;
    logic [7:0]  redundancy;
    logic [27:0] gap_cycles;
    logic        busy;
    logic        start_frame;
    logic        maxdetect;
    logic        start_sending;
    logic [15:0] segment_num;
    logic [7:0]  txid;
    logic [7:0]  aux;
    logic [15:0] seg_count;
    logic        round_done;
    logic        active;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int trunc_seg = -1;
    int m_base = 0;
    int m_sc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          done_q[$];
    int          sc_q[$];

    send_scheduler #(
        .SEG_W(16), .ID_W(8), .MAX_RED(MAX_RED), .GAP_W(28), .AUX_W(8)
    ) dut (
        .clk125MHz(clk125MHz), .RST_N(RST_N), .enable(enable), .frame_mode(frame_mode),
        .interleave(interleave), .seg_max(seg_max), .redundancy(redundancy),
        .gap_cycles(gap_cycles), .busy(busy), .start_frame(start_frame),
        .maxdetect(maxdetect), .start_sending(start_sending), .segment_num(segment_num),
        .txid(txid), .aux(aux), .seg_count(seg_count), .round_done(round_done),
        .active(active)
    );

    always #4 clk125MHz = ~clk125MHz;
    always @(posedge clk125MHz) cyc <= cyc + 1;

    // Source reports exhaustion while the chosen segment is being issued.
    assign maxdetect = (trunc_seg >= 0) && start_sending && (int'(segment_num) == trunc_seg);

    always @(negedge clk125MHz) begin
        if (start_sending) begin
            obs_q.push_back({txid, segment_num, aux});
            obs_cyc.push_back(cyc);
        end
        if (round_done) begin
            done_q.push_back(cyc);
            sc_q.push_back(int'(seg_count));
        end
    end

    function automatic logic [31:0] pack(input int i, input int g);
        return {8'(i), 16'(g), 8'((m_base + g) % 256)};
    endfunction

    // Expected packet list of one round from the ordering rules.
    task automatic model_round(input int s_in, input int r_in, input bit il, input int trunc);
        int s;
        int r;
        s = (s_in == 0) ? 1 : s_in;
        r = (r_in == 0) ? 1 : ((r_in > MAX_RED) ? MAX_RED : r_in);
        if (trunc >= 0 && trunc < s) s = trunc + 1;
        if (!il) begin
            for (int i = 1; i <= r; i++)
                for (int g = 0; g < s; g++) exp_q.push_back(pack(i, g));
        end else begin
            for (int g = 0; g < s; g++)
                for (int i = 1; i <= r; i++) exp_q.push_back(pack(i, g));
        end
        m_sc = s;
        m_base = (m_base + s) % 256;
    endtask

    task automatic clear_obs();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); done_q.delete(); sc_q.delete();
    endtask

    task automatic nstep();
        @(negedge clk125MHz);
        #1;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_q.size() < n && k < 4000) begin
            nstep();
            k++;
        end
        n_vec++;
        if (done_q.size() < n) begin
            n_err++;
            $display("FAIL round_done_timeout got %0d want %0d", done_q.size(), n);
        end
    endtask

    task automatic set_params(input int s, input int r, input bit il, input int gap);
        seg_max = 16'(s); redundancy = 8'(r); interleave = il; gap_cycles = 28'(gap);
    endtask

    task automatic frame_round(input int s, input int r, input bit il, input int gap,
                               input int trunc, input bit poke, output int t0);
        nstep();
        set_params(s, r, il, gap);
        trunc_seg = trunc; frame_mode = 1'b1; enable = 1'b1; start_frame = 1'b1;
        @(posedge clk125MHz);
        #1 t0 = cyc;
        nstep();
        start_frame = 1'b0;
        if (poke) begin
            nstep(); start_frame = 1'b1;
            nstep(); start_frame = 1'b0;
        end
    endtask

    task automatic free_round(input int s, input int r, input bit il, input int gap,
                              input int nrounds, output int t0);
        nstep();
        set_params(s, r, il, gap);
        trunc_seg = -1; frame_mode = 1'b0; enable = 1'b1;
        @(posedge clk125MHz);
        #1 t0 = cyc;
        if (nrounds > 1) wait_done(nrounds - 1);
        nstep();
        enable = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; enable = 1'b0; frame_mode = 1'b0; interleave = 1'b0; busy = 1'b0;
        start_frame = 1'b0; set_params(1, 1, 0, 0);
        repeat (3) nstep();
        n_vec++;
        if ({start_sending, segment_num, txid, aux, seg_count, round_done, active} !==
            {1'b0, 16'd0, 8'd1, 8'd0, 16'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got %b %0d %0d %0d %0d %b %b want 0 0 1 0 0 0 0",
                     start_sending, segment_num, txid, aux, seg_count, round_done, active);
        end
        nstep();
        RST_N = 1'b1;
        m_base = 0;
    endtask

    task automatic test_block();
        int t0;
        clear_obs();
        model_round(3, 2, 0, -1);
        free_round(3, 2, 0, 4, 1, t0);
        wait_done(1);
        repeat (10) nstep();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL block_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL block_pkt[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
            n_vec++;
            if (i > 0 && obs_cyc[i] - obs_cyc[i-1] != 7) begin
                n_err++; $display("FAIL block_period[%0d] got %0d want 7", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        n_vec++;
        if (obs_cyc.size() > 0 && obs_cyc[0] != t0 + 5) begin
            n_err++; $display("FAIL block_latency got %0d want %0d", obs_cyc[0], t0 + 5);
        end
        n_vec++;
        if (done_q.size() != 1 || obs_cyc.size() == 0 || done_q[0] != obs_cyc[obs_cyc.size()-1] + 2) begin
            n_err++; $display("FAIL block_done got %0d rounds want 1 at last pulse + 2", done_q.size());
        end
        n_vec++;
        if (active !== 1'b0) begin
            n_err++; $display("FAIL block_idle_active got %b want 0", active);
        end
    endtask

    task automatic test_interleave();
        int t0;
        clear_obs();
        model_round(2, 3, 1, -1);
        model_round(2, 3, 1, -1);
        free_round(2, 3, 1, 2, 2, t0);
        wait_done(2);
        repeat (10) nstep();
        n_vec++;
        if (obs_q.size() != exp_q.size() || done_q.size() != 2) begin
            n_err++; $display("FAIL ilv_count got %0d/%0d want %0d/2", obs_q.size(), done_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL ilv_pkt[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (obs_cyc.size() > 6 && done_q.size() > 0 && obs_cyc[6] != done_q[0] + 4) begin
            n_err++; $display("FAIL ilv_b2b_latency got %0d want %0d", obs_cyc[6], done_q[0] + 4);
        end
    endtask

    task automatic test_busy();
        int t0;
        int fall;
        clear_obs();
        model_round(1, 1, 0, -1);
        frame_round(1, 1, 0, 10, -1, 0, t0);
        repeat (2) nstep();
        busy = 1'b1;
        repeat (5) nstep();
        busy = 1'b0;
        fall = cyc;
        wait_done(1);
        n_vec++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL busy_pkt got %0d pulses want 1 (%h)", obs_q.size(), exp_q[0]);
        end
        n_vec++;
        if (obs_cyc.size() > 0 && obs_cyc[0] != fall + 11) begin
            n_err++; $display("FAIL busy_latency got %0d want %0d", obs_cyc[0], fall + 11);
        end
    endtask

    task automatic test_truncate();
        int t0;
        clear_obs();
        model_round(150, 1, 0, 41);
        frame_round(150, 1, 0, 0, 41, 0, t0);
        wait_done(1);
        repeat (20) nstep();
        n_vec++;
        if (obs_q.size() != 42 || sc_q.size() != 1 || sc_q[0] != m_sc) begin
            n_err++; $display("FAIL trunc_count got %0d pkts sc %0d want 42 sc %0d",
                              obs_q.size(), (sc_q.size() > 0) ? sc_q[0] : -1, m_sc);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL trunc_pkt[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (active !== 1'b0 || done_q.size() != 1) begin
            n_err++; $display("FAIL trunc_idle got active %b rounds %0d want 0 1", active, done_q.size());
        end
        clear_obs();
        model_round(150, 1, 0, -1);
        frame_round(150, 1, 0, 0, -1, 0, t0);
        wait_done(1);
        n_vec++;
        if (obs_q.size() != 150 || sc_q.size() != 1 || sc_q[0] != 150) begin
            n_err++; $display("FAIL trunc_cleared got %0d pkts want 150", obs_q.size());
        end
        n_vec++;
        if (obs_q.size() == 150 && obs_q[149] !== exp_q[149]) begin
            n_err++; $display("FAIL trunc_cleared_last got %h want %h", obs_q[149], exp_q[149]);
        end
    endtask

    task automatic test_clamp();
        int t0;
        int tbl_s[3] = '{2, 1, 0};
        int tbl_r[3] = '{0, 9, 2};
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            model_round(tbl_s[k], tbl_r[k], 0, -1);
            frame_round(tbl_s[k], tbl_r[k], 0, 1, -1, 0, t0);
            wait_done(1);
            n_vec++;
            if (obs_q.size() != exp_q.size() || sc_q.size() != 1 || sc_q[0] != m_sc) begin
                n_err++; $display("FAIL clamp%0d_count got %0d want %0d", k, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL clamp%0d_pkt[%0d] got %h want %h", k, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int t0, s, r, gap, tr;
        bit il;
        for (int n = 0; n < 12; n++) begin
            clear_obs();
            s   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
            r   = $urandom_range(0, 6);
            il  = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 5);
            tr  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1;
            model_round(s, r, il, tr);
            frame_round(s, r, il, gap, tr, exp_q.size() >= 2, t0);
            wait_done(1);
            repeat (10) nstep();
            trunc_seg = -1;
            n_vec++;
            if (obs_q.size() != exp_q.size() || sc_q.size() != 1 || sc_q[0] != m_sc) begin
                n_err++; $display("FAIL rnd%0d_count got %0d pkts %0d rounds want %0d pkts 1 round sc %0d",
                                  n, obs_q.size(), done_q.size(), exp_q.size(), m_sc);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rnd%0d_pkt[%0d] got %h want %h", n, i, obs_q[i], exp_q[i]);
                end
                n_vec++;
                if (i == 0 && obs_cyc[0] != t0 + gap + 1) begin
                    n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", n, obs_cyc[0], t0 + gap + 1);
                end else if (i > 0 && obs_cyc[i] - obs_cyc[i-1] != gap + 3) begin
                    n_err++; $display("FAIL rnd%0d_period[%0d] got %0d want %0d", n, i,
                                      obs_cyc[i] - obs_cyc[i-1], gap + 3);
                end
            end
            n_vec++;
            if (done_q.size() > 0 && obs_cyc.size() > 0 && done_q[0] != obs_cyc[obs_cyc.size()-1] + 2) begin
                n_err++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", n, done_q[0],
                                  obs_cyc[obs_cyc.size()-1] + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        clear_obs();
        frame_round(5, 1, 0, 8, -1, 0, t0);
        while (obs_q.size() < 2 && cyc < t0 + 100) nstep();
        repeat (4) nstep();
        #1 RST_N = 1'b0;
        #1;
        n_vec++;
        if ({start_sending, segment_num, txid, aux, seg_count, round_done, active} !==
            {1'b0, 16'd0, 8'd1, 8'd0, 16'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_state got %b %0d %0d %0d %0d %b %b want 0 0 1 0 0 0 0",
                     start_sending, segment_num, txid, aux, seg_count, round_done, active);
        end
        nstep();
        n_vec++;
        if (obs_q.size() != 2 || done_q.size() != 0) begin
            n_err++; $display("FAIL rst_mid_partial got %0d pkts %0d rounds want 2 0", obs_q.size(), done_q.size());
        end
        RST_N = 1'b1;
        m_base = 0;
        clear_obs();
        model_round(2, 1, 0, -1);
        free_round(2, 1, 0, 3, 1, t0);
        wait_done(1);
        n_vec++;
        if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            n_err++; $display("FAIL rst_restart got %0d pkts first %h want 2 first %h",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx, exp_q[0]);
        end
        n_vec++;
        if (obs_cyc.size() > 0 && obs_cyc[0] != t0 + 4) begin
            n_err++; $display("FAIL rst_restart_latency got %0d want %0d", obs_cyc[0], t0 + 4);
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_interleave();
        test_busy();
        test_truncate();
        test_clamp();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
